// File: rtl/pixel_plot_writer.sv
// Pixel FIFO and framebuffer write port: buffers sprite pixels, maps (x,y) to a linear
// address, drops off-screen pixels. Optional colour-key transparency via PLOT_TRANSPARENT_EN.
module pixel_plot_writer #(
  parameter int          DEPTH           = 8,
  parameter int          SCREEN_W        = 160,
  parameter int          SCREEN_H        = 120,
  parameter logic [11:0] TRANSPARENT_KEY = 12'h000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_x,
  input  logic [6:0]  pix_y,
  input  logic [11:0] pix_colour,
  input  logic        pix_clear,
  input  logic        pix_last,
  input  logic        mem_busy,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_data,
  output logic        done,
  output logic [7:0]  drop_count
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 29;
  localparam logic [8:0] W_LIM = 9'(SCREEN_W);
  localparam logic [7:0] H_LIM = 8'(SCREEN_H);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               mem_we_reg, mem_we_next;
  logic [14:0]        mem_addr_reg, mem_addr_next;
  logic [11:0]        mem_data_reg, mem_data_next;
  logic               done_reg, done_next;
  logic [7:0]         drop_count_reg, drop_count_next;

  // Storage is read asynchronously at the head so a pixel pushed on one edge can pop on the next.
  logic [ENTRY_W-1:0] fifo_mem [DEPTH];

  logic               full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [7:0]         head_x;
  logic [6:0]         head_y;
  logic [11:0]        head_colour;
  logic               head_clear;
  logic               head_last;
  logic               in_range;
  logic               is_key;
  logic               write_ok;
  logic               drop;
  logic [14:0]        lin_addr;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign pix_ready = resetn && !full;
  assign push      = pix_valid && pix_ready;
  assign pop       = (state_reg == ACTIVE) && !mem_busy;

  assign head = fifo_mem[rd_ptr_reg];
  assign {head_x, head_y, head_colour, head_clear, head_last} = head;

  assign in_range = ({1'b0, head_x} < W_LIM) && ({1'b0, head_y} < H_LIM);

`ifdef PLOT_TRANSPARENT_EN
  assign is_key = !head_clear && (head_colour == TRANSPARENT_KEY);
`else
  // Key stays referenced but is masked off, so the comparison folds away.
  assign is_key = 1'b0 && (head_colour == TRANSPARENT_KEY);
`endif

  assign write_ok = pop && in_range && !is_key;
  assign drop     = pop && !(in_range && !is_key);

  // y*160 as shift-add; fits 15 bits for every in-range coordinate.
  assign lin_addr = {1'b0, head_y, 7'd0} + {3'd0, head_y, 5'd0} + {7'd0, head_x};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {pix_x, pix_y, pix_colour, pix_clear, pix_last};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (push) state_next = ACTIVE;
      ACTIVE:  if (pop && !push && (count_reg == CNT_W'(1))) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    mem_we_next     = write_ok;
    mem_addr_next   = mem_addr_reg;
    mem_data_next   = mem_data_reg;
    done_next       = pop && head_last;
    drop_count_next = drop_count_reg;
    if (write_ok) begin
      mem_addr_next = lin_addr;
      mem_data_next = head_clear ? 12'h000 : head_colour;
    end
    if (drop && (drop_count_reg != 8'hFF)) begin
      drop_count_next = drop_count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      done_reg       <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_data_reg   <= mem_data_next;
      done_reg       <= done_next;
      drop_count_reg <= drop_count_next;
    end
  end

  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_data   = mem_data_reg;
  assign done       = done_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_pixel_plot_writer.sv
// Scoreboard bench for pixel_plot_writer: accepted pixels are turned into expected
// writes/drops by a reference model; a negedge monitor matches them against the port.
module tb_pixel_plot_writer;

  localparam int DEPTH    = 8;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int KEY      = 12'h000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [11:0] pix_colour;
  logic        pix_clear;
  logic        pix_last;
  logic        mem_busy;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_data;
  logic        done;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  pixel_plot_writer #(
    .DEPTH(DEPTH), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .TRANSPARENT_KEY(12'h000)
  ) dut (
    .clk(clk), .resetn(resetn), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .pix_clear(pix_clear),
    .pix_last(pix_last), .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .done(done), .drop_count(drop_count)
  );

  typedef struct {
    bit drop;
    bit last;
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   occ = 0;
  int   model_drop = 0;
  int   writes_seen = 0;
  int   last_we_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input int col,
                                 input bit clr, input bit lst);
    exp_t e;
    e.drop = (x >= SCREEN_W) || (y >= SCREEN_H);
`ifdef PLOT_TRANSPARENT_EN
    if (!clr && (col == KEY)) e.drop = 1'b1;
`endif
    e.addr = y * SCREEN_W + x;
    e.data = clr ? 0 : col;
    e.last = lst;
    return e;
  endfunction

  // Monitor: silent drops leave no trace, so they are skipped before matching.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn === 1'b1 && (mem_we || done)) begin
      while (exp_q.size() > 0 && exp_q[0].drop && !exp_q[0].last) void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got we=%0b done=%0b, required no activity", mem_we, done);
      end else begin
        e = exp_q.pop_front();
        if (e.drop) begin
          check("dropped_last_we", int'(mem_we), 0);
          check("dropped_last_done", int'(done), 1);
          $display("done (dropped last) cyc=%0d", cyc);
        end else begin
          check("we", int'(mem_we), 1);
          check("addr", int'(mem_addr), e.addr);
          check("data", int'(mem_data), e.data);
          check("done", int'(done), int'(e.last));
          $display("write addr=%0d data=%03h done=%0b cyc=%0d", mem_addr, mem_data, done, cyc);
        end
      end
      if (mem_we) begin
        writes_seen++;
        last_we_cyc = cyc;
      end
    end
  end

  // One clock of stimulus; called and returns at a negedge.
  task automatic drive(input bit v, input int x, input int y, input int col,
                       input bit clr, input bit lst, input bit busy);
    exp_t e;
    bit   acc;
    bit   popd;
    pix_valid  = v;
    pix_x      = x[7:0];
    pix_y      = y[6:0];
    pix_colour = col[11:0];
    pix_clear  = clr;
    pix_last   = lst;
    mem_busy   = busy;
    #1;
    check("pix_ready", int'(pix_ready), int'(occ < DEPTH));
    acc = v && (occ < DEPTH);
    @(posedge clk);
    popd = (occ > 0) && !busy;
    if (acc) begin
      e = model(x, y, col, clr, lst);
      exp_q.push_back(e);
      if (e.drop && model_drop < 255) model_drop++;
    end
    occ = occ + int'(acc) - int'(popd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && occ > 0; i++) idle(1);
    idle(2);
    while (exp_q.size() > 0 && exp_q[0].drop && !exp_q[0].last) void'(exp_q.pop_front());
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_we"}, int'(mem_we), 0);
    check({tag, "_addr"}, int'(mem_addr), 0);
    check({tag, "_data"}, int'(mem_data), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_drops"}, int'(drop_count), 0);
    check({tag, "_ready"}, int'(pix_ready), 0);
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #1 reset_checks("async_reset");
    exp_q.delete();
    occ = 0;
    model_drop = 0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int w0;
    int rel;
    resetn = 1'b0;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_colour = '0;
    pix_clear = 1'b0; pix_last = 1'b0; mem_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    resetn = 1'b1;

    // Single pixel: address 3*160+5 = 485, write and done one cycle after the push edge.
    drive(1'b1, 5, 3, 12'hF80, 1'b0, 1'b1, 1'b0);
    p0 = cyc;
    drain();
    check("latency", last_we_cyc, p0 + 1);

    // Stall: eight fill the FIFO, the ninth is refused, release gives eight back-to-back writes.
    for (int i = 0; i < 9; i++)
      drive(1'b1, i * 3, i + 1, int'($urandom_range(1, 4095)), 1'b0, (i == 7), 1'b1);
    check("full_occupancy", occ, DEPTH);
    w0 = writes_seen;
    rel = cyc;
    drain();
    check("burst_writes", writes_seen - w0, 8);
    check("burst_end", last_we_cyc, rel + 8);

    // Off-screen drops and saturation.
    do_reset();
    w0 = writes_seen;
    drive(1'b1, 160, 0, 12'h123, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 0, 120, 12'h456, 1'b0, 1'b0, 1'b0);
    drain();
    check("drop_two", int'(drop_count), 2);
    check("drop_no_write", writes_seen - w0, 0);
    for (int i = 0; i < 300; i++)
      drive(1'b1, int'($urandom_range(160, 255)), int'($urandom_range(0, 127)), 12'h7F7, 1'b0, 1'b0, 1'b0);
    drain();
    check("drop_saturate", int'(drop_count), 255);
    check("drop_model", int'(drop_count), model_drop);

    // Key colour and clear pixels.
    do_reset();
    drive(1'b1, 10, 10, 12'h000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 11, 10, 12'h3A5, 1'b1, 1'b1, 1'b0);
    drain();
    check("key_drops", int'(drop_count), model_drop);

    // Streaming: 20 pushes give 20 consecutive writes.
    w0 = writes_seen;
    drive(1'b1, 0, 0, 12'hABC, 1'b0, 1'b0, 1'b0);
    p0 = cyc;
    for (int i = 1; i < 20; i++)
      drive(1'b1, int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
            int'($urandom_range(1, 4095)), 1'b0, (i == 19), 1'b0);
    drain();
    check("stream_writes", writes_seen - w0, 20);
    check("stream_end", last_we_cyc, p0 + 20);

    // Reset mid-stream: buffered pixels and the pending last are discarded.
    for (int i = 0; i < 10; i++)
      drive(1'b1, i, i, int'($urandom_range(1, 4095)), 1'b0, 1'b1, (i >= 6));
    do_reset();
    w0 = writes_seen;
    idle(4);
    check("post_reset_writes", writes_seen - w0, 0);

    // Randomised traffic with stalls, drops, clears and lasts.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
            ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 4095)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    drain();
    check("random_drops", int'(drop_count), model_drop);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_plot_writer.md
# pixel_plot_writer

- Accepts the pixel stream produced by the sprite control blocks: x, y, 12-bit colour, a clear flag and a last flag.
- Buffers the stream in a small FIFO and converts each pixel to a linear video-memory address.
- Issues single-cycle write strobes to the framebuffer port, honouring the memory's busy stall.
- Sits between the sprite controllers and the 160x120 framebuffer. Reports end-of-sprite and drops off-screen pixels.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- TRANSPARENT_KEY, 12'h000, colour skipped when transparency is compiled in

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising-edge
- resetn  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel present on pix_* this cycle
- pix_ready  out  1  FIFO can accept; transfer on rising edge with pix_valid && pix_ready
- pix_x  in  8  column
- pix_y  in  7  row
- pix_colour  in  12  RGB444
- pix_clear  in  1  erase pixel; always written, bypasses transparency
- pix_last  in  1  final pixel of a sprite pass
- mem_busy  in  1  framebuffer cannot take a write; stalls pops
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  15  y*SCREEN_W + x
- mem_data  out  12  colour to write
- done  out  1  one-cycle pulse when the last-flagged entry leaves the FIFO
- drop_count  out  8  saturating count of discarded pixels

## Operation
- FIFO entry = {x, y, colour, clear, last}; 29 bits. Separate read/write pointers plus occupancy count, 0..DEPTH.
- Push: occurs on a rising edge with pix_valid && pix_ready. pix_ready = !full while resetn high; pix_ready = 0 while resetn low.
- Full FIFO: no push, even if a pop happens the same edge (no same-cycle pass-through).
- Pop: occurs on each rising edge where the FIFO is non-empty and mem_busy = 0.
- A popped entry is dropped (no write) if x >= SCREEN_W or y >= SCREEN_H.
- A popped entry is also dropped when transparency applies (see Configuration).
- Each drop increments drop_count by 1, saturating at 255.
- For a non-dropped pop, the output register loads:
  - mem_addr = (y<<7)+(y<<5)+x; 15-bit, no overflow for in-range values
  - mem_data = clear ? 12'h000 : colour
  - mem_we = 1
- On any edge without a non-dropped pop, mem_we = 0. mem_addr and mem_data hold their previous values.
- done = 1 for exactly the cycle after an edge that pops an entry with last = 1, whether written or dropped. Otherwise done = 0.
- Simultaneous push and pop: both occur; occupancy is unchanged.
- Pointers wrap modulo DEPTH.
- Two-state control FSM:
  - IDLE (FIFO empty) -> ACTIVE on push
  - ACTIVE -> IDLE when a pop empties the FIFO with no simultaneous push

## Timing
- Reset (resetn low, asynchronous):
  - FIFO emptied, FSM to IDLE
  - mem_we = 0, mem_addr = 0, mem_data = 0, done = 0, drop_count = 0
- Latency: a pixel pushed at edge N, with the FIFO previously empty and mem_busy low, is popped at edge N+1. mem_we/done are high during cycle N+1..N+2.
- Throughput: one pixel per clock when mem_busy stays low.
- mem_busy is sampled only at pop edges. Raising it mid-stream freezes the FIFO head. mem_we falls on the next edge.
- resetn asserted mid-stream discards all buffered pixels. No done pulse is issued for a discarded last.

## Configuration
- PLOT_TRANSPARENT_EN defined:
  - A popped entry with clear = 0 and colour == TRANSPARENT_KEY is dropped and counted in drop_count.
  - Entries with clear = 1 are always written.
- Not defined: colour is never compared against the key. Every in-range pixel is written.

## Test plan
- Reset, then push (x=5, y=3, colour=12'hF80, last=1), mem_busy=0 -> one mem_we cycle with mem_addr=485, mem_data=12'hF80; done high in that same cycle.
- Hold mem_busy=1, push 8 pixels with DEPTH=8 -> pix_ready falls after the 8th push and the 9th is not taken. Release busy -> 8 consecutive mem_we cycles in push order.
- Push (x=160, y=0) and (x=0, y=120) -> no mem_we, drop_count=2. Then 300 off-screen pixels -> drop_count saturates at 255.
- With PLOT_TRANSPARENT_EN: push colour 12'h000 clear=0 -> dropped. Push colour 12'h3A5 clear=1 -> written with mem_data=12'h000. Without the macro, the first pixel is written.
- Continuous push of 20 pixels with mem_busy=0 -> 20 back-to-back mem_we cycles and pix_ready never low. Assert resetn low after 10 -> all outputs 0 immediately and no done.
